cache_miss_sequencer: RTL
=========================

# cache_miss_sequencer

Sequences a cache miss in one set of the 4-way MSI L1: selects a victim way (first invalid way, else the LRU way), writes the victim back to memory if it is Modified, issues the line fill, waits for the fill response, then reports completion and updates the LRU state. It sits between the cache controller's miss path, the tag/state array, the LRU counter block and the memory-side request channel.

## Interface
- NUM_WAYS, 4, associativity; only 4 is supported
- ADDR_W, 32, byte address width
- OFFSET_W, 6, line offset bits (64 B lines)
- INDEX_W, 6, set index bits
- TIMEOUT_CYCLES, 255, fill-wait limit; used only with FILL_TIMEOUT_EN
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- miss_valid  in  1  miss request
- miss_ready  out  1  high only in IDLE
- miss_addr  in  ADDR_W  missing line address
- way_valid  in  NUM_WAYS  per-way valid bit for the indexed set
- way_state  in  2*NUM_WAYS  per-way MSI state (way i at [2i+1:2i])
- way_tag  in  (ADDR_W-OFFSET_W-INDEX_W)*NUM_WAYS  per-way tags, way i in slice i
- lru_way  in  2  LRU victim from the LRU counter block
- victim_inv  out  1  one-cycle pulse: invalidate victim_way in the tag array
- victim_way  out  NUM_WAYS  one-hot selected victim, held from SELECT exit until IDLE
- wb_req_valid / wb_req_ready  out/in  1  writeback request handshake
- wb_addr  out  ADDR_W  {victim tag, index, OFFSET_W'b0}
- fill_req_valid / fill_req_ready  out/in  1  fill request handshake
- fill_addr  out  ADDR_W  miss_addr with offset zeroed
- fill_resp_valid  in  1  fill data has been written into the array
- done_valid  out  1  one-cycle completion pulse
- done_err  out  1  qualifies done_valid; fill timed out
- lru_access_valid  out  1  one-cycle pulse to the LRU block
- lru_access_way  out  NUM_WAYS  one-hot way to make MRU

## Operation
- States: IDLE, SELECT, WRITEBACK, FILL_REQ, FILL_WAIT, COMPLETE.
- IDLE: miss_ready=1. On miss_valid, capture miss_addr and go to SELECT.
- SELECT (1 cycle): victim = lowest-numbered way with way_valid=0. If all ways are valid, victim = lru_way. Register victim_way and the victim tag. Pulse victim_inv.
  - If the victim is valid with state M (2'b10): go to WRITEBACK.
  - Otherwise: go to FILL_REQ.
- WRITEBACK: wb_req_valid=1 with wb_addr stable until wb_req_ready is sampled high. Then go to FILL_REQ.
- FILL_REQ: fill_req_valid=1 with fill_addr stable until fill_req_ready. Then go to FILL_WAIT.
- FILL_WAIT: wait for fill_resp_valid, then go to COMPLETE. fill_resp_valid in any other state is ignored.
- COMPLETE (1 cycle): done_valid=1, done_err=0, lru_access_valid=1, lru_access_way=victim_way. Then go to IDLE.
- Valid signals never drop before their handshake completes, and their payloads never change while valid is high.
- MSI encoding: I=0, S=1, M=2. Encoding 3 is treated as I.

## Timing
- Reset: state=IDLE; every output is 0 except miss_ready=1. An in-flight miss is abandoned with no done_valid.
- Zero-wait latency from the miss accept edge to done_valid:
  - Clean victim: 4 cycles (SELECT, FILL_REQ, FILL_WAIT, COMPLETE).
  - Dirty victim: 5 cycles.
- Each cycle a ready signal stays low adds one cycle. Each cycle without fill_resp_valid adds one cycle.
- Back-to-back misses: a new miss can be accepted in the cycle after COMPLETE.
- way_* inputs and lru_way are sampled only in SELECT.

## Configuration
- FILL_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to FILL_WAIT and counts each cycle spent there.
  - On reaching TIMEOUT_CYCLES with no response, go to COMPLETE with done_err=1 and lru_access_valid=0.
  - A response arriving on the same cycle the limit is reached counts as success.
- FILL_TIMEOUT_EN undefined: FILL_WAIT waits indefinitely, done_err is tied to 0, and no counter is present.

## Structure
- Shared msi_pkg holds the MSI state encodings, the FSM state typedef and the line geometry constants.
- Sub-module victim_select is combinational: it takes way_valid, way_state and lru_way and outputs the one-hot victim plus a dirty flag.

## Test plan
- way_valid=4'b1011, miss_addr=0x1234_5678 -> victim_way=4'b0100, no wb_req, fill_addr=0x1234_5640, done_valid 4 cycles after accept, lru_access_way=4'b0100.
- All ways valid, lru_way=3, way3 in state M with tag 0xABCDE -> wb_addr={0xABCDE, index, 0}, then fill, done_valid at cycle 5.
- wb_req_ready held low 3 cycles -> wb_req_valid and wb_addr stable throughout, done_valid at cycle 8.
- rst asserted in FILL_WAIT, then fill_resp_valid driven -> no done_valid, miss_ready=1 the next cycle.
- FILL_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no response -> done_valid with done_err=1 and lru_access_valid=0.
- miss_valid held high through completion -> second miss accepted the cycle after COMPLETE; stray fill_resp_valid in IDLE ignored.

Source files
------------

// File: rtl/msi_pkg.sv
// Shared definitions for the L1 miss path: MSI encodings, sequencer FSM states
// and line geometry (64 B lines, 64 sets, 4 ways, 32-bit byte addresses).
package msi_pkg;

    localparam int NUM_WAYS = 4;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 6;
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int TIMER_W  = 8;

    typedef enum logic [1:0] {
        MSI_I    = 2'd0,
        MSI_S    = 2'd1,
        MSI_M    = 2'd2,
        MSI_RSVD = 2'd3
    } msi_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WRITEBACK,
        ST_FILL_REQ,
        ST_FILL_WAIT,
        ST_COMPLETE
    } state_e;

    function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [1:0] idx);
        logic [NUM_WAYS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/cache_miss_sequencer_if.sv
// Miss-path bundle between the cache controller side, tag/LRU arrays and
// the memory request channel; the sequencer uses the slave modport.
interface cache_miss_sequencer_if
    import msi_pkg::*;
();
    logic                      miss_valid;
    logic                      miss_ready;
    logic [ADDR_W-1:0]         miss_addr;
    logic [NUM_WAYS-1:0]       way_valid;
    logic [2*NUM_WAYS-1:0]     way_state;
    logic [TAG_W*NUM_WAYS-1:0] way_tag;
    logic [1:0]                lru_way;
    logic                      victim_inv;
    logic [NUM_WAYS-1:0]       victim_way;
    logic                      wb_req_valid;
    logic                      wb_req_ready;
    logic [ADDR_W-1:0]         wb_addr;
    logic                      fill_req_valid;
    logic                      fill_req_ready;
    logic [ADDR_W-1:0]         fill_addr;
    logic                      fill_resp_valid;
    logic                      done_valid;
    logic                      done_err;
    logic                      lru_access_valid;
    logic [NUM_WAYS-1:0]       lru_access_way;

    modport slave (
        input  miss_valid, miss_addr, way_valid, way_state, way_tag, lru_way,
               wb_req_ready, fill_req_ready, fill_resp_valid,
        output miss_ready, victim_inv, victim_way, wb_req_valid, wb_addr,
               fill_req_valid, fill_addr, done_valid, done_err,
               lru_access_valid, lru_access_way
    );

    modport master (
        output miss_valid, miss_addr, way_valid, way_state, way_tag, lru_way,
               wb_req_ready, fill_req_ready, fill_resp_valid,
        input  miss_ready, victim_inv, victim_way, wb_req_valid, wb_addr,
               fill_req_valid, fill_addr, done_valid, done_err,
               lru_access_valid, lru_access_way
    );
endinterface

// File: rtl/victim_select.sv
// Combinational victim choice: lowest invalid way, else the LRU way; flags a
// victim that is valid and Modified (encoding 3 counts as Invalid).
module victim_select
    import msi_pkg::*;
(
    input  logic [NUM_WAYS-1:0]   way_valid_i,
    input  logic [2*NUM_WAYS-1:0] way_state_i,
    input  logic [1:0]            lru_way_i,
    output logic [NUM_WAYS-1:0]   victim_o,
    output logic [1:0]            victim_idx_o,
    output logic                  dirty_o
);
    logic found;

    always_comb begin
        found        = 1'b0;
        victim_idx_o = lru_way_i;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!found && !way_valid_i[i]) begin
                victim_idx_o = 2'(i);
                found        = 1'b1;
            end
        end
        victim_o = way_onehot(victim_idx_o);
        dirty_o  = way_valid_i[victim_idx_o] &&
                   (msi_e'(way_state_i[{victim_idx_o, 1'b0} +: 2]) == MSI_M);
    end
endmodule

// File: rtl/cache_miss_sequencer.sv
// Sequences one L1 miss: victim select, optional writeback, line fill, done.
// Define FILL_TIMEOUT_EN to bound FILL_WAIT by TIMEOUT_CYCLES (reports done_err).
module cache_miss_sequencer
    import msi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_miss_sequencer_if.slave bus
);
    state_e                     state_q, state_d;
    logic [ADDR_W-OFFSET_W-1:0] line_q;
    logic [NUM_WAYS-1:0]        victim_q;
    logic [TAG_W-1:0]           vtag_q;
    logic [NUM_WAYS-1:0]        sel_victim;
    logic [1:0]                 sel_idx;
    logic                       sel_dirty;
    logic                       timeout_hit;
    logic                       fill_err;
    logic [OFFSET_W-1:0]        unused_offset;

    assign unused_offset = bus.miss_addr[OFFSET_W-1:0];

    victim_select u_victim_select (
        .way_valid_i  (bus.way_valid),
        .way_state_i  (bus.way_state),
        .lru_way_i    (bus.lru_way),
        .victim_o     (sel_victim),
        .victim_idx_o (sel_idx),
        .dirty_o      (sel_dirty)
    );

`ifdef FILL_TIMEOUT_EN
    logic [TIMER_W-1:0] timer_q;
    logic               err_q;

    // Timer sits at zero outside FILL_WAIT, so it is clear on every entry.
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_FILL_WAIT) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == ST_FILL_WAIT) begin
            err_q <= timeout_hit && !bus.fill_resp_valid;
        end
    end

    assign timeout_hit = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign fill_err    = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign fill_err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && bus.miss_valid) begin
            line_q <= bus.miss_addr[ADDR_W-1:OFFSET_W];
        end
        if (state_q == ST_SELECT) begin
            victim_q <= sel_victim;
            vtag_q   <= bus.way_tag[int'(sel_idx)*TAG_W +: TAG_W];
        end
    end

    always_comb begin
        state_d              = state_q;
        bus.miss_ready       = 1'b0;
        bus.victim_inv       = 1'b0;
        bus.victim_way       = '0;
        bus.wb_req_valid     = 1'b0;
        bus.wb_addr          = '0;
        bus.fill_req_valid   = 1'b0;
        bus.fill_addr        = '0;
        bus.done_valid       = 1'b0;
        bus.done_err         = 1'b0;
        bus.lru_access_valid = 1'b0;
        bus.lru_access_way   = '0;
        case (state_q)
            ST_IDLE: begin
                bus.miss_ready = 1'b1;
                if (bus.miss_valid) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                bus.victim_inv = 1'b1;
                state_d        = sel_dirty ? ST_WRITEBACK : ST_FILL_REQ;
            end
            ST_WRITEBACK: begin
                bus.victim_way   = victim_q;
                bus.wb_req_valid = 1'b1;
                bus.wb_addr      = {vtag_q, line_q[INDEX_W-1:0], {OFFSET_W{1'b0}}};
                if (bus.wb_req_ready) state_d = ST_FILL_REQ;
            end
            ST_FILL_REQ: begin
                bus.victim_way     = victim_q;
                bus.fill_req_valid = 1'b1;
                bus.fill_addr      = {line_q, {OFFSET_W{1'b0}}};
                if (bus.fill_req_ready) state_d = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: begin
                bus.victim_way = victim_q;
                if (bus.fill_resp_valid || timeout_hit) state_d = ST_COMPLETE;
            end
            ST_COMPLETE: begin
                bus.victim_way       = victim_q;
                bus.done_valid       = 1'b1;
                bus.done_err         = fill_err;
                bus.lru_access_valid = !fill_err;
                bus.lru_access_way   = victim_q;
                state_d              = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule
